store_size_ctrl: RTL and testbench
==================================

// Module: store_size_ctrl
// PURPOSE
//  Store-side partner of the load-size stage: writes SB/SH/SW data from register B into data memory.
//  SW writes the word directly; SB/SH do read-modify-write (read word, merge low lanes, write back).
//  Sits between the multicycle control unit / register B and the synchronous data memory port.
//  Handshake with control unit: start pulse -> busy -> one-cycle done pulse.
// PARAMETERS
//  MEM_RD_LAT  1   cycles from mem_addr driven (mem_we=0) to mem_rdata valid; legal 1..7
// PORTS
//  clock      in   1   clock, rising edge
//  reset      in   1   reset, asynchronous, active-low
//  start      in   1   one-cycle request; sampled only in IDLE
//  size       in   2   01=byte, 10=halfword, 11=word, 00=illegal
//  addr       in   32  byte address of the store
//  wdata      in   32  register B value
//  mem_rdata  in   32  memory read data
//  mem_addr   out  32  memory address (word-aligned: {addr[31:2],2'b00})
//  mem_wdata  out  32  merged write word
//  mem_we     out  1   write strobe, high exactly one cycle per store
//  busy       out  1   high from cycle after accepted start until DONE inclusive
//  done       out  1   one-cycle completion pulse
//  misalign   out  1   only with STORE_ALIGN_CHECK_EN, else tied 0
// BEHAVIOUR
//  Reset: state=IDLE; mem_addr, mem_wdata=0; mem_we, busy, done, misalign=0; latched addr/wdata/size=0.
//  On accepted start, latch addr, wdata, size; later input changes ignored until back in IDLE.
//  FSM: IDLE -> (size=11) WRITE; (01/10) READ; (00) DONE (no write).
//       READ: mem_we=0, counter runs MEM_RD_LAT cycles -> MERGE.
//       MERGE: capture mem_rdata, build word -> WRITE.
//       WRITE: mem_we=1, mem_wdata=merged word -> DONE.  DONE: done=1 -> IDLE.
//  Merge: byte -> {rdata[31:8], wdata[7:0]}; half -> {rdata[31:16], wdata[15:0]}; word -> wdata.
//  Latency start->done: word 2 cycles; byte/half MEM_RD_LAT+3 cycles; illegal 1 cycle.
//  start while busy: ignored, no queueing. start in the DONE cycle: ignored.
//  mem_addr held stable from READ through WRITE; mem_wdata valid only while mem_we=1.
//  Reset mid-operation: immediate return to IDLE, mem_we drops asynchronously, no partial write.
//  Counter saturates; no wrap beyond MEM_RD_LAT.
// CONFIGURATION
//  STORE_ALIGN_CHECK_EN defined: size=10 with addr[0]!=0 or size=11 with addr[1:0]!=0
//   -> no memory access, go to DONE, misalign=1 together with done (one cycle).
//  Not defined: misalign tied 0; addr[1:0] ignored, store proceeds on aligned word.
// STRUCTURE
//  Shared include ls_defs.vh: size codes SZ_BYTE/SZ_HALF/SZ_WORD/SZ_NONE, FSM state encodings
//   (IDLE, READ, MERGE, WRITE, DONE) reused by the load-size stage.
//  One sub-module: store_merge (combinational lane merge: size, rdata, wdata -> merged word).
// TESTING
//  SW: addr=0x10, wdata=0xDEADBEEF -> mem_we 1 cycle after start, mem_wdata=0xDEADBEEF, done at +2.
//  SB: mem word 0x11223344, wdata=0xAABBCCDD -> mem_wdata=0x112233DD, done at MEM_RD_LAT+3.
//  SH: same mem word, wdata=0x0000BEEF -> mem_wdata=0x1122BEEF; rerun with MEM_RD_LAT=3 -> done at +6.
//  start pulsed again while busy and size=00 request -> second start ignored; size=00 gives done at +1, no mem_we.
//  reset low during READ of SB -> all outputs 0 immediately, no mem_we pulse after release.
//  STORE_ALIGN_CHECK_EN: SW at addr=0x13 -> misalign=done=1 at +1, mem_we never asserted.

Source files
------------

// File: rtl/store_size_ctrl_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// store_size_ctrl_pkg : size codes, FSM states and alignment helper
// Rev 1.0
// ----------------------------------------------------------------------------
package store_size_ctrl_pkg;

  typedef enum logic [1:0] {
    SZ_NONE = 2'b00,
    SZ_BYTE = 2'b01,
    SZ_HALF = 2'b10,
    SZ_WORD = 2'b11
  } size_e;

  // Shared with the load-size stage, so keep the encodings stable.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_READ  = 3'd1,
    ST_MERGE = 3'd2,
    ST_WRITE = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  function automatic logic is_misaligned(input size_e size, input logic [1:0] lsb);
    return ((size == SZ_HALF) && lsb[0]) || ((size == SZ_WORD) && (lsb != 2'b00));
  endfunction

endpackage
`default_nettype wire

// File: rtl/store_size_ctrl_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// store_size_ctrl_if : control-unit request and data-memory port bundle
// Rev 1.0
// ----------------------------------------------------------------------------
interface store_size_ctrl_if;
  logic        start;
  logic [1:0]  size;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] mem_rdata;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_we;
  logic        busy;
  logic        done;
  logic        misalign;

  modport master (
    output start, size, addr, wdata, mem_rdata,
    input  mem_addr, mem_wdata, mem_we, busy, done, misalign
  );

  modport slave (
    input  start, size, addr, wdata, mem_rdata,
    output mem_addr, mem_wdata, mem_we, busy, done, misalign
  );
endinterface
`default_nettype wire

// File: rtl/store_size_ctrl_merge.sv
`default_nettype none
// ----------------------------------------------------------------------------
// store_size_ctrl_merge : combinational low-lane merge of store data into word
// Rev 1.0
// ----------------------------------------------------------------------------
module store_size_ctrl_merge
  import store_size_ctrl_pkg::*;
(
  input  size_e       size_i,
  input  logic [31:0] rdata_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] merged_o
);

  always_comb begin
    merged_o = rdata_i;
    unique case (size_i)
      SZ_BYTE: merged_o = {rdata_i[31:8], wdata_i[7:0]};
      SZ_HALF: merged_o = {rdata_i[31:16], wdata_i[15:0]};
      SZ_WORD: merged_o = wdata_i;
      default: merged_o = rdata_i;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/store_size_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// store_size_ctrl : SB/SH/SW store sequencer (RMW for sub-word), optional
//                   alignment check via STORE_ALIGN_CHECK_EN
// Rev 1.0
// ----------------------------------------------------------------------------
module store_size_ctrl
  import store_size_ctrl_pkg::*;
#(
  parameter int unsigned MEM_RD_LAT = 1
) (
  input  logic             clock,
  input  logic             reset,
  store_size_ctrl_if.slave bus
);

  localparam logic [2:0] LAT_LAST = 3'(MEM_RD_LAT - 1);
`ifdef STORE_ALIGN_CHECK_EN
  localparam bit ALIGN_CHECK = 1'b1;
`else
  localparam bit ALIGN_CHECK = 1'b0;
`endif

  state_e      state_q, state_d;
  size_e       size_q, size_d;
  logic [31:2] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        mis_q, mis_d;
  logic [31:0] merged;
  logic        start_mis;

  assign start_mis = ALIGN_CHECK && is_misaligned(size_e'(bus.size), bus.addr[1:0]);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      size_q  <= SZ_NONE;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      cnt_q   <= '0;
      mis_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      size_q  <= size_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      cnt_q   <= cnt_d;
      mis_q   <= mis_d;
    end
  end

  always_comb begin
    state_d = state_q;
    size_d  = size_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    cnt_d   = cnt_q;
    mis_d   = mis_q;
    unique case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        mis_d = 1'b0;
        if (bus.start) begin
          size_d  = size_e'(bus.size);
          addr_d  = bus.addr[31:2];
          wdata_d = bus.wdata;
          if (start_mis) begin
            mis_d   = 1'b1;
            state_d = ST_DONE;
          end else begin
            case (size_e'(bus.size))
              SZ_WORD:          state_d = ST_WRITE;
              SZ_BYTE, SZ_HALF: state_d = ST_READ;
              default:          state_d = ST_DONE;
            endcase
          end
        end
      end
      // Counter parks at its last value rather than wrapping.
      ST_READ: begin
        if (cnt_q == LAT_LAST) state_d = ST_MERGE;
        else                   cnt_d   = cnt_q + 3'd1;
      end
      ST_MERGE: begin
        rdata_d = bus.mem_rdata;
        state_d = ST_WRITE;
      end
      ST_WRITE: state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  store_size_ctrl_merge u_merge (
    .size_i   (size_q),
    .rdata_i  (rdata_q),
    .wdata_i  (wdata_q),
    .merged_o (merged)
  );

  assign bus.mem_addr  = {addr_q, 2'b00};
  assign bus.mem_we    = (state_q == ST_WRITE);
  assign bus.mem_wdata = (state_q == ST_WRITE) ? merged : '0;
  assign bus.busy      = (state_q != ST_IDLE);
  assign bus.done      = (state_q == ST_DONE);
  assign bus.misalign  = (state_q == ST_DONE) && mis_q;

endmodule
`default_nettype wire

// File: tb/tb_store_size_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_store_size_ctrl : directed bench, two DUTs (read latency 1 and 3)
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_store_size_ctrl;
  import store_size_ctrl_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        sel;
  logic        start;
  logic [1:0]  size;
  logic [31:0] addr, wdata;
  int          n_chk = 0;
  int          n_fail = 0;

  store_size_ctrl_if ba();
  store_size_ctrl_if bb();

  store_size_ctrl #(.MEM_RD_LAT(1)) u_dut_a (.clock(clk), .reset(rst_n), .bus(ba));
  store_size_ctrl #(.MEM_RD_LAT(3)) u_dut_b (.clock(clk), .reset(rst_n), .bus(bb));

  assign ba.start = start & ~sel;
  assign bb.start = start & sel;
  assign ba.size  = size;
  assign bb.size  = size;
  assign ba.addr  = addr;
  assign bb.addr  = addr;
  assign ba.wdata = wdata;
  assign bb.wdata = wdata;

  // Memory model: per-port read pipeline of the matching latency
  logic [31:0]      mem [0:15];
  logic [31:0]      pipe_a;
  logic [2:0][31:0] pipe_b;
  logic             pre_we;
  logic [3:0]       pre_idx;
  logic [31:0]      pre_data;

  always @(posedge clk) begin
    if (pre_we)    mem[pre_idx] <= pre_data;
    if (ba.mem_we) mem[ba.mem_addr[5:2]] <= ba.mem_wdata;
    if (bb.mem_we) mem[bb.mem_addr[5:2]] <= bb.mem_wdata;
    pipe_a <= mem[ba.mem_addr[5:2]];
    pipe_b <= {pipe_b[1:0], mem[bb.mem_addr[5:2]]};
  end
  assign ba.mem_rdata = pipe_a;
  assign bb.mem_rdata = pipe_b[2];

  logic        o_we, o_busy, o_done, o_mis;
  logic [31:0] o_wdata, o_addr;
  assign o_we    = sel ? bb.mem_we    : ba.mem_we;
  assign o_busy  = sel ? bb.busy      : ba.busy;
  assign o_done  = sel ? bb.done      : ba.done;
  assign o_mis   = sel ? bb.misalign  : ba.misalign;
  assign o_wdata = sel ? bb.mem_wdata : ba.mem_wdata;
  assign o_addr  = sel ? bb.mem_addr  : ba.mem_addr;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  task automatic preload(input logic [3:0] idx, input logic [31:0] data);
    @(negedge clk);
    pre_we = 1'b1; pre_idx = idx; pre_data = data;
    @(negedge clk);
    pre_we = 1'b0;
  endtask

  // Cycle c = c-th negedge after the start pulse; rep1/rep2 re-pulse start.
  task automatic run_store(input logic s, input logic [1:0] sz, input logic [31:0] a,
                           input logic [31:0] wd, input int rep1, input int rep2,
                           output int done_cyc, output int we_cyc, output int we_cnt,
                           output logic [31:0] we_data, output logic [31:0] we_addr,
                           output logic mis, output logic busy1);
    done_cyc = -1; we_cyc = -1; we_cnt = 0; we_data = '0; we_addr = '0;
    mis = 1'b0; busy1 = 1'b0;
    @(negedge clk);
    sel = s; size = sz; addr = a; wdata = wd; start = 1'b1;
    for (int c = 1; c <= 30; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (c == 1) busy1 = o_busy;
      if (o_we) begin
        we_cnt++;
        if (we_cyc < 0) begin we_cyc = c; we_data = o_wdata; we_addr = o_addr; end
      end
      if (o_done && done_cyc < 0) begin done_cyc = c; mis = o_mis; end
      if (c == rep1 || c == rep2) begin
        start = 1'b1; size = SZ_WORD; addr = 32'h10; wdata = 32'h0;
      end
      if (done_cyc >= 0 && c >= done_cyc + 4) break;
    end
    start = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int          dc, wc, wn, nb;
    logic [31:0] wdv, wav;
    logic        mis, b1;
    rst_n = 1'b0; sel = 1'b0; start = 1'b0; size = SZ_NONE; addr = '0; wdata = '0;
    pre_we = 1'b0; pre_idx = '0; pre_data = '0;
    repeat (2) @(negedge clk);
    chk("rst_a_addr",  ba.mem_addr,  32'h0);
    chk("rst_a_wdata", ba.mem_wdata, 32'h0);
    chk("rst_a_we",    32'(ba.mem_we),   32'h0);
    chk("rst_a_busy",  32'(ba.busy),     32'h0);
    chk("rst_a_done",  32'(ba.done),     32'h0);
    chk("rst_a_mis",   32'(ba.misalign), 32'h0);
    chk("rst_b_busy",  32'(bb.busy),     32'h0);
    chk("rst_b_addr",  bb.mem_addr,  32'h0);
    preload(4'd4, 32'h0000_0000);
    preload(4'd5, 32'h1122_3344);
    preload(4'd6, 32'h1122_3344);
    preload(4'd8, 32'h0000_0000);
    preload(4'd9, 32'h0BAD_F00D);
    @(negedge clk);
    rst_n = 1'b1;

    run_store(1'b0, SZ_WORD, 32'h10, 32'hDEAD_BEEF, -1, -1, dc, wc, wn, wdv, wav, mis, b1);
    chk("sw_we_cyc", 32'(wc), 32'd1);
    chk("sw_done",   32'(dc), 32'd2);
    chk("sw_data",   wdv, 32'hDEAD_BEEF);
    chk("sw_addr",   wav, 32'h10);
    chk("sw_we_cnt", 32'(wn), 32'd1);
    chk("sw_busy",   32'(b1), 32'd1);
    chk("sw_mis",    32'(mis), 32'd0);

    run_store(1'b0, SZ_BYTE, 32'h15, 32'hAABB_CCDD, -1, -1, dc, wc, wn, wdv, wav, mis, b1);
    chk("sb_we_cyc", 32'(wc), 32'd3);
    chk("sb_done",   32'(dc), 32'd4);
    chk("sb_data",   wdv, 32'h1122_33DD);
    chk("sb_addr",   wav, 32'h14);
    chk("sb_we_cnt", 32'(wn), 32'd1);

    run_store(1'b0, SZ_HALF, 32'h18, 32'h0000_BEEF, -1, -1, dc, wc, wn, wdv, wav, mis, b1);
    chk("sh_done",   32'(dc), 32'd4);
    chk("sh_data",   wdv, 32'h1122_BEEF);

    run_store(1'b1, SZ_WORD, 32'h20, 32'hFEED_FACE, -1, -1, dc, wc, wn, wdv, wav, mis, b1);
    chk("sw3_done",  32'(dc), 32'd2);
    chk("sw3_data",  wdv, 32'hFEED_FACE);

    run_store(1'b1, SZ_HALF, 32'h18, 32'h0000_CAFE, -1, -1, dc, wc, wn, wdv, wav, mis, b1);
    chk("sh3_we_cyc", 32'(wc), 32'd5);
    chk("sh3_done",   32'(dc), 32'd6);
    chk("sh3_data",   wdv, 32'h1122_CAFE);

    // Re-pulse while busy (cycle 1) and in the DONE cycle (4): both ignored.
    run_store(1'b0, SZ_BYTE, 32'h14, 32'h0000_0099, 1, 4, dc, wc, wn, wdv, wav, mis, b1);
    chk("busy_done",   32'(dc), 32'd4);
    chk("busy_data",   wdv, 32'h1122_3399);
    chk("busy_we_cnt", 32'(wn), 32'd1);
    chk("busy_mem10",  mem[4], 32'hDEAD_BEEF);

    run_store(1'b0, SZ_NONE, 32'h10, 32'h1234_5678, -1, -1, dc, wc, wn, wdv, wav, mis, b1);
    chk("ill_done",   32'(dc), 32'd1);
    chk("ill_we_cnt", 32'(wn), 32'd0);
    chk("ill_mis",    32'(mis), 32'd0);

    @(negedge clk);
    sel = 1'b1; size = SZ_BYTE; addr = 32'h24; wdata = 32'h77; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("rmid_busy", 32'(o_busy), 32'd1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rmid_we",    32'(o_we),   32'd0);
    chk("rmid_busy0", 32'(o_busy), 32'd0);
    chk("rmid_done",  32'(o_done), 32'd0);
    chk("rmid_addr",  o_addr,  32'h0);
    chk("rmid_wdata", o_wdata, 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    wn = 0; nb = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (o_we)   wn++;
      if (o_busy) nb++;
    end
    chk("rmid_no_we",  32'(wn), 32'd0);
    chk("rmid_idle",   32'(nb), 32'd0);
    chk("rmid_mem24",  mem[9], 32'h0BAD_F00D);

    run_store(1'b0, SZ_WORD, 32'h13, 32'h5555_5555, -1, -1, dc, wc, wn, wdv, wav, mis, b1);
`ifdef STORE_ALIGN_CHECK_EN
    chk("mis_done",   32'(dc), 32'd1);
    chk("mis_flag",   32'(mis), 32'd1);
    chk("mis_we_cnt", 32'(wn), 32'd0);
    chk("mis_mem10",  mem[4], 32'hDEAD_BEEF);
`else
    chk("mis_done",   32'(dc), 32'd2);
    chk("mis_flag",   32'(mis), 32'd0);
    chk("mis_addr",   wav, 32'h10);
    chk("mis_data",   wdv, 32'h5555_5555);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
